// File: rtl/pdl_pkg.sv
// Shared widths and helpers for the PDL pointer/index block.
// Latency: none (declarations only); no backpressure.
package pdl_pkg;
  localparam int PDL_AW    = 10;
  localparam int PDL_DEPTH = 1 << PDL_AW;
  localparam int MF_W      = 32;
  localparam logic [MF_W-PDL_AW-1:0] MF_ZPAD = '0;

  typedef logic [PDL_AW-1:0] pdl_ptr_t;
  typedef logic [MF_W-1:0]   mf_t;

  function automatic mf_t mf_word(input pdl_ptr_t v);
    return {MF_ZPAD, v};
  endfunction
endpackage

// File: rtl/pdl_pointer_if.sv
// Sequencer-facing bundle of the PDL pointer block: phase strobes, decoded controls, MF read-back.
// Latency: wires only; no backpressure (phase-stepped, every request is taken).
interface pdl_pointer_if;
  import pdl_pkg::*;

  logic     state_alu;
  logic     state_write;
  logic     state_mmu;
  logic     state_fetch;
  mf_t      ob;
  logic     nop;
  logic     ldpdlp;
  logic     ldpdlx;
  logic     srcpdlpop;
  logic     destpdl_p;
  logic     srcpdlptr;
  logic     srcpdlidx;
  pdl_ptr_t pdlptr;
  pdl_ptr_t pdlidx;
  mf_t      mf;
  logic     mfdrive;
  logic     pdl_ovf;
  logic     pdl_unf;

  modport master (
    output state_alu, state_write, state_mmu, state_fetch, ob, nop,
           ldpdlp, ldpdlx, srcpdlpop, destpdl_p, srcpdlptr, srcpdlidx,
    input  pdlptr, pdlidx, mf, mfdrive, pdl_ovf, pdl_unf
  );

  modport slave (
    input  state_alu, state_write, state_mmu, state_fetch, ob, nop,
           ldpdlp, ldpdlx, srcpdlpop, destpdl_p, srcpdlptr, srcpdlidx,
    output pdlptr, pdlidx, mf, mfdrive, pdl_ovf, pdl_unf
  );
endinterface

// File: rtl/pdl_updown_counter.sv
// Modulo-1024 load/inc/dec counter with wrap strobes; load beats count, inc+dec holds.
// Latency: 1 clk to q, strobes combinational; no backpressure.
module pdl_updown_counter
  import pdl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     ld,
  input  pdl_ptr_t ld_val,
  input  logic     inc,
  input  logic     dec,
  output pdl_ptr_t q,
  output logic     wrap_up,
  output logic     wrap_dn
);
  localparam pdl_ptr_t PTR_MAX = pdl_ptr_t'(PDL_DEPTH - 1);

  logic step_up;
  logic step_dn;

  assign step_up = inc & ~dec & ~ld;
  assign step_dn = dec & ~inc & ~ld;
  assign wrap_up = step_up & (q == PTR_MAX);
  assign wrap_dn = step_dn & (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (step_up) begin
      q <= q + 1'b1;
    end else if (step_dn) begin
      q <= q - 1'b1;
    end
  end
endmodule

// File: rtl/pdl_pointer.sv
// PDL stack pointer and index registers: push at ALU end, load at WRITE end, pop at FETCH end; MF read-back.
// Latency: 1 clk per update, MF combinational; no backpressure. Optional bounds flags via PDL_BOUNDS_EN.
module pdl_pointer
  import pdl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  pdl_pointer_if.slave bus
);
  logic     pop_req;
  logic     push_req;
  logic     ld_ptr;
  logic     ld_idx;
  logic     pop_pend;
  logic     ptr_inc;
  logic     ptr_dec;
  logic     ptr_wrap_up;
  logic     ptr_wrap_dn;
  pdl_ptr_t ptr_q;
  pdl_ptr_t idx_q;
  logic     unused_ob_hi;

  assign pop_req  = bus.srcpdlpop & ~bus.nop & ~bus.destpdl_p;
  assign push_req = bus.destpdl_p & ~(bus.srcpdlpop & ~bus.nop);
  assign ld_ptr   = bus.state_write & bus.ldpdlp & ~bus.nop;
  assign ld_idx   = bus.state_write & bus.ldpdlx & ~bus.nop;
  assign ptr_inc  = bus.state_alu & push_req;
  assign ptr_dec  = bus.state_fetch & pop_pend;

  // Pop is decided in ALU but applied after the read in FETCH; a WRITE-phase load cancels it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_pend <= 1'b0;
    end else if (bus.state_alu) begin
      pop_pend <= pop_req;
    end else if (ld_ptr || bus.state_fetch) begin
      pop_pend <= 1'b0;
    end
  end

  pdl_updown_counter u_ptr (
    .clk     (clk),
    .reset   (reset),
    .ld      (ld_ptr),
    .ld_val  (bus.ob[PDL_AW-1:0]),
    .inc     (ptr_inc),
    .dec     (ptr_dec),
    .q       (ptr_q),
    .wrap_up (ptr_wrap_up),
    .wrap_dn (ptr_wrap_dn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else if (ld_idx) begin
      idx_q <= bus.ob[PDL_AW-1:0];
    end
  end

  assign bus.pdlptr  = ptr_q;
  assign bus.pdlidx  = idx_q;
  assign unused_ob_hi = ^bus.ob[MF_W-1:PDL_AW];

`ifdef PDL_BOUNDS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (reset || ld_ptr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ptr_wrap_up) ovf_q <= 1'b1;
      if (ptr_wrap_dn) unf_q <= 1'b1;
    end
  end

  assign bus.pdl_ovf = ovf_q;
  assign bus.pdl_unf = unf_q;
`else
  logic unused_wrap;

  assign unused_wrap = ptr_wrap_up | ptr_wrap_dn;
  assign bus.pdl_ovf = 1'b0;
  assign bus.pdl_unf = 1'b0;
`endif

  assign bus.mfdrive = (bus.srcpdlptr | bus.srcpdlidx) &
                       (bus.state_alu | bus.state_write | bus.state_mmu | bus.state_fetch);

  always_comb begin
    bus.mf = '0;
    if (bus.srcpdlptr) begin
      bus.mf = mf_word(ptr_q);
    end else if (bus.srcpdlidx) begin
      bus.mf = mf_word(idx_q);
    end
  end
endmodule

// File: tb/tb_pdl_pointer.sv
// Randomised and directed bench for pdl_pointer against an instruction-level model.
// Drives on negedge, samples 1 time unit after edges.
module tb_pdl_pointer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

`ifdef PDL_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // Reference state: what the pointer block should hold after each phase
  int m_ptr;
  int m_idx;
  bit m_ovf;
  bit m_unf;

  pdl_pointer_if bus ();

  pdl_pointer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.state_alu   = 1'b0;
    bus.state_write = 1'b0;
    bus.state_mmu   = 1'b0;
    bus.state_fetch = 1'b0;
    bus.ob          = '0;
    bus.nop         = 1'b0;
    bus.ldpdlp      = 1'b0;
    bus.ldpdlx      = 1'b0;
    bus.srcpdlpop   = 1'b0;
    bus.destpdl_p   = 1'b0;
    bus.srcpdlptr   = 1'b0;
    bus.srcpdlidx   = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_idx = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One full instruction: ALU, WRITE, MMU, FETCH, checking MF before and registers after each clock.
  task automatic run_instr(input bit pop, input bit push, input bit ldp, input bit ldx,
                           input bit nop, input logic [31:0] obv, input bit sp, input bit si);
    bit push_eff;
    bit pop_eff;
    bit ldp_eff;
    bit ldx_eff;
    logic [31:0] exp_mf;
    push_eff = push && !(pop && !nop);
    pop_eff  = pop && !nop && !push;
    ldp_eff  = ldp && !nop;
    ldx_eff  = ldx && !nop;
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      bus.srcpdlpop   = pop;
      bus.destpdl_p   = push;
      bus.ldpdlp      = ldp;
      bus.ldpdlx      = ldx;
      bus.nop         = nop;
      bus.ob          = obv;
      bus.srcpdlptr   = sp;
      bus.srcpdlidx   = si;
      bus.state_alu   = (ph == 0);
      bus.state_write = (ph == 1);
      bus.state_mmu   = (ph == 2);
      bus.state_fetch = (ph == 3);
      #1;
      exp_mf = sp ? 32'(m_ptr) : (si ? 32'(m_idx) : 32'h0);
      checks++;
      if (bus.mfdrive !== (sp | si)) begin
        failures++;
        $display("FAIL instr_mfdrive ph=%0d got=%b exp=%b", ph, bus.mfdrive, sp | si);
      end
      checks++;
      if (bus.mf !== exp_mf) begin
        failures++;
        $display("FAIL instr_mf ph=%0d got=%h exp=%h", ph, bus.mf, exp_mf);
      end
      @(posedge clk);
      #1;
      if (ph == 0 && push_eff) begin
        if (BOUNDS && m_ptr == 1023) m_ovf = 1'b1;
        m_ptr = (m_ptr + 1) % 1024;
      end
      if (ph == 1) begin
        if (ldp_eff) begin
          m_ptr = int'(obv % 1024);
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (ldx_eff) m_idx = int'(obv % 1024);
      end
      if (ph == 3 && pop_eff && !ldp_eff) begin
        if (BOUNDS && m_ptr == 0) m_unf = 1'b1;
        m_ptr = (m_ptr + 1023) % 1024;
      end
      checks++;
      if (bus.pdlptr !== 10'(m_ptr)) begin
        failures++;
        $display("FAIL instr_pdlptr ph=%0d got=%h exp=%h", ph, bus.pdlptr, 10'(m_ptr));
      end
      checks++;
      if (bus.pdlidx !== 10'(m_idx)) begin
        failures++;
        $display("FAIL instr_pdlidx ph=%0d got=%h exp=%h", ph, bus.pdlidx, 10'(m_idx));
      end
      checks++;
      if (bus.pdl_ovf !== m_ovf) begin
        failures++;
        $display("FAIL instr_ovf ph=%0d got=%b exp=%b", ph, bus.pdl_ovf, m_ovf);
      end
      checks++;
      if (bus.pdl_unf !== m_unf) begin
        failures++;
        $display("FAIL instr_unf ph=%0d got=%b exp=%b", ph, bus.pdl_unf, m_unf);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (bus.pdlptr !== 10'h000) begin
      failures++;
      $display("FAIL reset_pdlptr got=%h exp=000", bus.pdlptr);
    end
    checks++;
    if (bus.pdlidx !== 10'h000) begin
      failures++;
      $display("FAIL reset_pdlidx got=%h exp=000", bus.pdlidx);
    end
    checks++;
    if ({bus.pdl_ovf, bus.pdl_unf} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", bus.pdl_ovf, bus.pdl_unf);
    end
    checks++;
    if (bus.mfdrive !== 1'b0 || bus.mf !== 32'h0) begin
      failures++;
      $display("FAIL reset_mf got=%b/%h exp=0/0", bus.mfdrive, bus.mf);
    end
  endtask

  task automatic test_load();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0155, 0, 0);
    checks++;
    if (bus.pdlptr !== 10'h155 || bus.pdlidx !== 10'h000) begin
      failures++;
      $display("FAIL load_ptr got=%h/%h exp=155/000", bus.pdlptr, bus.pdlidx);
    end
    run_instr(0, 0, 1, 1, 0, 32'hFFFF_FE7A, 0, 0);
    checks++;
    if (bus.pdlptr !== 10'h27A || bus.pdlidx !== 10'h27A) begin
      failures++;
      $display("FAIL load_upper_ignored got=%h/%h exp=27a/27a", bus.pdlptr, bus.pdlidx);
    end
  endtask

  task automatic test_push_wrap();
    run_instr(0, 0, 1, 0, 0, 32'h0000_03FF, 0, 0);
    run_instr(0, 1, 0, 0, 0, 32'h0, 1, 0);
    checks++;
    if (bus.pdlptr !== 10'h000 || bus.pdl_ovf !== BOUNDS) begin
      failures++;
      $display("FAIL push_wrap got=%h ovf=%b exp=000 ovf=%b", bus.pdlptr, bus.pdl_ovf, BOUNDS);
    end
    // nop does not suppress the push
    run_instr(0, 1, 0, 0, 1, 32'h0, 0, 0);
    checks++;
    if (bus.pdlptr !== 10'h001) begin
      failures++;
      $display("FAIL push_under_nop got=%h exp=001", bus.pdlptr);
    end
  endtask

  task automatic test_pop_wrap();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0000, 0, 0);
    run_instr(1, 0, 0, 0, 0, 32'h0, 0, 0);
    checks++;
    if (bus.pdlptr !== 10'h3FF || bus.pdl_unf !== BOUNDS) begin
      failures++;
      $display("FAIL pop_wrap got=%h unf=%b exp=3ff unf=%b", bus.pdlptr, bus.pdl_unf, BOUNDS);
    end
    run_instr(0, 0, 1, 0, 0, 32'h0000_0044, 0, 0);
    checks++;
    if (bus.pdl_unf !== 1'b0 || bus.pdlptr !== 10'h044) begin
      failures++;
      $display("FAIL pop_flag_clear got=%h unf=%b exp=044 unf=0", bus.pdlptr, bus.pdl_unf);
    end
  endtask

  task automatic test_replace();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0020, 0, 0);
    run_instr(1, 1, 0, 0, 0, 32'h0, 1, 0);
    checks++;
    if (bus.pdlptr !== 10'h020) begin
      failures++;
      $display("FAIL replace_top got=%h exp=020", bus.pdlptr);
    end
  endtask

  task automatic test_mf();
    run_instr(0, 0, 0, 1, 0, 32'h0000_00AB, 0, 0);
    @(negedge clk);
    bus.state_alu = 1'b1;
    bus.srcpdlidx = 1'b1;
    #1;
    checks++;
    if (bus.mfdrive !== 1'b1 || bus.mf !== 32'h0000_00AB) begin
      failures++;
      $display("FAIL mf_idx got=%b/%h exp=1/000000ab", bus.mfdrive, bus.mf);
    end
    bus.srcpdlptr = 1'b1;
    #1;
    checks++;
    if (bus.mf !== 32'h0000_0020) begin
      failures++;
      $display("FAIL mf_ptr_priority got=%h exp=00000020", bus.mf);
    end
    bus.state_alu = 1'b0;
    #1;
    checks++;
    if (bus.mfdrive !== 1'b0) begin
      failures++;
      $display("FAIL mf_no_phase got=%b exp=0", bus.mfdrive);
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    run_instr(0, 0, 0, 0, 0, 32'h0, 0, 1);
  endtask

  task automatic test_load_priority();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0030, 0, 0);
    run_instr(1, 0, 1, 0, 0, 32'h0000_0010, 0, 0);
    checks++;
    if (bus.pdlptr !== 10'h010) begin
      failures++;
      $display("FAIL load_beats_pop got=%h exp=010", bus.pdlptr);
    end
    run_instr(0, 0, 0, 1, 1, 32'h0000_0155, 0, 0);
    checks++;
    if (bus.pdlidx !== 10'h0AB) begin
      failures++;
      $display("FAIL nop_blocks_ldx got=%h exp=0ab", bus.pdlidx);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0100, 0, 0);
    @(negedge clk);
    bus.destpdl_p = 1'b1;
    bus.state_alu = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pdlptr !== 10'h000) begin
      failures++;
      $display("FAIL reset_over_push got=%h exp=000", bus.pdlptr);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    model_reset();
    run_instr(0, 0, 1, 0, 0, 32'h0000_0005, 0, 0);
    @(negedge clk);
    bus.srcpdlpop = 1'b1;
    bus.state_alu = 1'b1;
    @(negedge clk);
    bus.state_alu   = 1'b0;
    bus.state_write = 1'b1;
    @(negedge clk);
    bus.state_write = 1'b0;
    bus.state_mmu   = 1'b1;
    reset           = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    bus.state_fetch = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pdlptr !== 10'h000 || bus.pdl_unf !== 1'b0) begin
      failures++;
      $display("FAIL reset_kills_pop got=%h unf=%b exp=000 unf=0", bus.pdlptr, bus.pdl_unf);
    end
    @(negedge clk);
    drive_idle();
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] obv;
    int sel;
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) obv = 32'($urandom_range(0, 1)) | ($urandom() & 32'hFFFF_FC00);
      else if (sel == 1) obv = 32'($urandom_range(1022, 1023)) | ($urandom() & 32'hFFFF_FC00);
      else obv = $urandom();
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), obv,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_load();
    test_push_wrap();
    test_pop_wrap();
    test_replace();
    test_mf();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdl_pointer.md
PDL_POINTER -- requirements
Module: pdl_pointer

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; clk in, reset in, all state updates on posedge clk.
REQ-002 SHALL have ports: clk in 1 system clock; reset in 1 sync active-high reset.
REQ-003 SHALL have ports: state_alu, state_write, state_mmu, state_fetch in 1 each, one-hot machine-cycle phase.
REQ-004 SHALL have ports: ob in 32 output bus, load data; nop in 1 current instruction suppressed.
REQ-005 SHALL have ports: ldpdlp in 1 load pointer from ob; ldpdlx in 1 load index from ob.
REQ-006 SHALL have ports: srcpdlpop in 1 M-source pop; destpdl_p in 1 push destination.
REQ-007 SHALL have ports: srcpdlptr in 1 read pointer to MF; srcpdlidx in 1 read index to MF.
REQ-008 SHALL have ports: pdlptr out 10 stack pointer; pdlidx out 10 index register; both consumed by PDL buffer control.
REQ-009 SHALL have ports: mf out 32 MF bus data; mfdrive out 1 MF bus enable.
REQ-010 SHALL have ports: pdl_ovf out 1 sticky overflow; pdl_unf out 1 sticky underflow.

Function
REQ-011 Pointer load SHALL occur at the clock ending state_write when ldpdlp & ~nop: pdlptr <= ob[9:0]; ob[31:10] ignored.
REQ-012 Index load SHALL occur at the clock ending state_write when ldpdlx & ~nop: pdlidx <= ob[9:0].
REQ-013 Push: when destpdl_p & ~(srcpdlpop & ~nop), pdlptr SHALL increment by 1 at the clock ending state_alu, before the write in state_write.
REQ-014 Pop: when srcpdlpop & ~nop & ~destpdl_p, pdlptr SHALL decrement by 1 at the clock ending state_fetch, after the read.
REQ-015 Pop and push in the same instruction SHALL leave pdlptr unchanged (replace-top semantics).
REQ-016 Arithmetic SHALL be modulo 1024: 1023+1 -> 0, 0-1 -> 1023.
REQ-017 Load SHALL take priority over any count in the same instruction; a pending pop decrement in that instruction's state_fetch SHALL be cancelled.
REQ-018 nop SHALL suppress pop and load; destpdl_p push increment SHALL still occur (matches PDL write-enable behaviour).
REQ-019 mfdrive SHALL = (srcpdlptr | srcpdlidx) & (state_alu | state_write | state_mmu | state_fetch), combinational.
REQ-020 mf SHALL = {22'b0, pdlptr} when srcpdlptr, else {22'b0, pdlidx} when srcpdlidx, else 0; srcpdlptr has priority.
REQ-021 pdlptr and pdlidx SHALL be direct register outputs, zero combinational delay after clk.

Reset
REQ-022 On reset: pdlptr=0, pdlidx=0, pdl_ovf=0, pdl_unf=0, pending-pop state cleared.
REQ-023 Reset asserted mid-instruction SHALL abort any pending increment/decrement/load; no update on the reset cycle.

Configuration
REQ-024 Macro PDL_BOUNDS_EN: when defined, pdl_ovf sets on increment wrap 1023->0, pdl_unf sets on decrement wrap 0->1023, both sticky until reset or pointer load.
REQ-025 Without PDL_BOUNDS_EN, pdl_ovf and pdl_unf SHALL be tied 0 and no bounds logic synthesised.

Structure
REQ-026 Shared package pdl_pkg SHALL hold PDL_AW=10, PDL_DEPTH=1024, MF width 32 and the zero-pad constant.
REQ-027 One sub-module pdl_updown_counter (10-bit load/inc/dec with wrap flags) SHALL implement pdlptr; pdlidx is a plain load register.

Verification
REQ-028 Reset, then ldpdlp with ob=0x0000_0155 -> pdlptr=0x155 after state_write, pdlidx=0.
REQ-029 pdlptr=0x3FF, push -> pdlptr=0x000 after state_alu; pdl_ovf=1 iff PDL_BOUNDS_EN.
REQ-030 pdlptr=0x000, pop -> pdlptr=0x3FF after state_fetch; pdl_unf=1 iff PDL_BOUNDS_EN; subsequent ldpdlp clears flag.
REQ-031 pdlptr=0x020, pop+push same instruction -> pdlptr stays 0x020 through all phases.
REQ-032 pdlidx=0x0AB, srcpdlidx in state_alu -> mfdrive=1, mf=0x0000_00AB; srcpdlptr+srcpdlidx -> mf=pdlptr.
REQ-033 Pop with ldpdlp (ob=0x010) same instruction -> pdlptr=0x010, no decrement; nop with ldpdlx -> pdlidx unchanged.
